seven_seg_scanner: RTL and testbench

//  - Downstream consumer of the binary-to-BCD converter: latches its packed BCD result and drives the board's

---
 rtl/seven_seg_scanner_if.sv | 27 ++
 rtl/seven_seg_scanner.sv | 144 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_if.sv
// Bus between the BCD converter side and the multiplexed 7-segment display.
// The scanner uses the slave modport.
interface seven_seg_scanner_if #(
    parameter int unsigned DECIMAL_DIGITS = 8
);
    logic [DECIMAL_DIGITS*4-1:0] BCD;
    logic                        LOAD;
    logic [DECIMAL_DIGITS-1:0]   ANODE;
    logic [6:0]                  CATHODE;
    logic                        ACTIVE;

    modport master (
        output BCD,
        output LOAD,
        input  ANODE,
        input  CATHODE,
        input  ACTIVE
    );

    modport slave (
        input  BCD,
        input  LOAD,
        output ANODE,
        output CATHODE,
        output ACTIVE
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode 7-segment scanner with per-slot ghosting gap and tear-free
// frame-boundary updates. Optional feature macro: LEADING_ZERO_BLANK_EN.
module seven_seg_scanner #(
    parameter int unsigned DECIMAL_DIGITS = 8,
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned GAP_CYCLES     = 1000
) (
    input logic                clk,
    input logic                reset,
    seven_seg_scanner_if.slave bus
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);
    localparam int unsigned IdxW = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam int unsigned BcdW = DECIMAL_DIGITS * 4;

    typedef enum logic {StIdle, StScan} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [BcdW-1:0]   shadow_q, shadow_d;
    logic [BcdW-1:0]   display_q, display_d;
    logic [DECIMAL_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]        cathode_q, cathode_d;
    logic              cathode_en;
    logic              active_q;
    logic [3:0]        nibble;
    logic              in_gap;
    logic              digit_on;
`ifdef LEADING_ZERO_BLANK_EN
    logic [IdxW-1:0]   top_idx;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = 7'b0111111;
        endcase
        return g;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        display_d = display_q;
        case (state_q)
            StIdle: begin
                if (bus.LOAD) begin
                    state_d   = StScan;
                    shadow_d  = bus.BCD;
                    display_d = bus.BCD;
                    cnt_d     = '0;
                    idx_d     = '0;
                end
            end
            StScan: begin
                if (bus.LOAD) shadow_d = bus.BCD;
                if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
                    cnt_d = '0;
                    if (idx_q == IdxW'(DECIMAL_DIGITS - 1)) begin
                        idx_d = '0;
                        // Frame boundary: a coincident LOAD bypasses the shadow so the newest value wins.
                        display_d = bus.LOAD ? bus.BCD : shadow_q;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from next-state values so they line up with cnt/idx cycle-for-cycle.
    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < int'(DECIMAL_DIGITS); i++) begin
            if (idx_d == IdxW'(i)) nibble = display_d[i*4 +: 4];
        end

`ifdef LEADING_ZERO_BLANK_EN
        top_idx = '0;
        for (int i = 0; i < int'(DECIMAL_DIGITS); i++) begin
            if (display_d[i*4 +: 4] != 4'h0) top_idx = IdxW'(i);
        end
        digit_on = (idx_d <= top_idx);
`else
        digit_on = 1'b1;
`endif

        in_gap  = (cnt_d < CntW'(GAP_CYCLES));
        anode_d = '1;
        if (state_d == StScan && !in_gap && digit_on) begin
            for (int i = 0; i < int'(DECIMAL_DIGITS); i++) begin
                if (idx_d == IdxW'(i)) anode_d[i] = 1'b0;
            end
        end

        cathode_d  = (state_d == StScan) ? glyph(nibble) : 7'h7F;
        // Segments may only switch while every anode is off.
        cathode_en = (state_d != StScan) || in_gap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            display_q <= '0;
            anode_q   <= '1;
            cathode_q <= 7'h7F;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            display_q <= display_d;
            anode_q   <= anode_d;
            if (cathode_en) cathode_q <= cathode_d;
            active_q  <= (state_d == StScan);
        end
    end

    assign bus.ANODE   = anode_q;
    assign bus.CATHODE = cathode_q;
    assign bus.ACTIVE  = active_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (4 digits, 8-cycle slots, 2-cycle gap) against a time-based model.
module tb_seven_seg_scanner;

    localparam int D = 4;
    localparam int R = 8;
    localparam int G = 2;
    localparam int F = D * R;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    seven_seg_scanner_if #(.DECIMAL_DIGITS(D)) bus ();

    seven_seg_scanner #(
        .DECIMAL_DIGITS(D),
        .REFRESH_DIV   (R),
        .GAP_CYCLES    (G)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model: cycles elapsed since scanning began, plus the shadow and displayed values.
    bit          m_active;
    int          m_t;
    logic [15:0] m_shad, m_disp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_shad   <= '0;
            m_disp   <= '0;
        end else if (!m_active) begin
            if (bus.LOAD) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_shad   <= bus.BCD;
                m_disp   <= bus.BCD;
            end
        end else begin
            m_t <= m_t + 1;
            if (((m_t + 1) % F) == 0) m_disp <= bus.LOAD ? bus.BCD : m_shad;
            if (bus.LOAD) m_shad <= bus.BCD;
        end
    end

    function automatic logic [6:0] glyph_ref(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
        return tbl[n];
    endfunction

    function automatic void model_out(output logic [3:0] a, output logic [6:0] c,
                                      output logic act);
        int   slot, pos, top;
        logic lit;
        if (!m_active) begin
            a = 4'hF; c = 7'h7F; act = 1'b0;
            return;
        end
        slot = (m_t / R) % D;
        pos  = m_t % R;
        c    = glyph_ref(4'((m_disp >> (slot * 4)) & 16'hF));
        lit  = (pos >= G);
        top  = 0;
        for (int i = 0; i < D; i++) if (((m_disp >> (i * 4)) & 16'hF) != 0) top = i;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > top) lit = 1'b0;
`endif
        a   = lit ? ~(4'b0001 << slot) : 4'hF;
        act = 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (time %0t)", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT against model.
    always @(negedge clk) begin
        logic [3:0] ea;
        logic [6:0] ec;
        logic       eact;
        model_out(ea, ec, eact);
        check("anode", 32'(bus.ANODE), 32'(ea));
        check("cathode", 32'(bus.CATHODE), 32'(ec));
        check("active", 32'(bus.ACTIVE), 32'(eact));
    end

    // Pin both the model and the DUT to hand-computed values.
    task automatic pin(input string name, input logic [3:0] a, input logic [6:0] c);
        logic [3:0] ea;
        logic [6:0] ec;
        logic       eact;
        model_out(ea, ec, eact);
        check({name, " model anode"}, 32'(ea), 32'(a));
        check({name, " model cathode"}, 32'(ec), 32'(c));
        check({name, " dut anode"}, 32'(bus.ANODE), 32'(a));
        check({name, " dut cathode"}, 32'(bus.CATHODE), 32'(c));
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [15:0] v);
        bus.BCD  = v;
        bus.LOAD = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0;
    endtask

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000, G8 = 7'b0000000, GD = 7'b0111111;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit Blank = 1'b1;
`else
    localparam bit Blank = 1'b0;
`endif

    initial begin
        logic [15:0] r;
        reset    = 1'b1;
        bus.LOAD = 1'b0;
        bus.BCD  = '0;
        wait_n(2);
        reset = 1'b0;

        // Idle: blank with no LOAD.
        wait_n(100);
        pin("idle", 4'hF, 7'h7F);
        check("idle active", 32'(bus.ACTIVE), 32'd0);

        // 1234: t counts cycles since scan start (t=0 at this negedge).
        load(16'h1234);
        check("scan active", 32'(bus.ACTIVE), 32'd1);
        pin("t0 gap", 4'hF, G4);
        wait_n(2);  pin("t2 d0", 4'hE, G4);
        wait_n(6);  pin("t8 gap d1", 4'hF, G3);
        wait_n(2);  pin("t10 d1", 4'hD, G3);
        wait_n(8);  pin("t18 d2", 4'hB, G2);
        wait_n(8);  pin("t26 d3", 4'h7, G1);
        wait_n(32); pin("t58 d3 repeat", 4'h7, G1);

        // Mid-frame LOAD in digit 1 slot (t=74).
        wait_n(16);
        load(16'h5678);
        wait_n(9);  pin("t84 d2 old", 4'hB, G2);
        wait_n(8);  pin("t92 d3 old", 4'h7, G1);
        wait_n(6);  pin("t98 d0 new", 4'hE, G8);
        wait_n(24); pin("t122 d3 new", 4'h7, G5);

        // LOAD on the frame-boundary cycle (t=127).
        wait_n(5);
        load(16'h00A7);
        wait_n(2);  pin("t130 d0 7", 4'hE, G7);
        wait_n(8);  pin("t138 d1 dash", 4'hD, GD);
        wait_n(8);  pin("t146 d2 zero", Blank ? 4'hF : 4'hB, G0);
        wait_n(8);  pin("t154 d3 zero", Blank ? 4'hF : 4'h7, G0);

        // Reset during digit 2 lit phase of 4321.
        load(16'h4321);
        wait_n(27); pin("t182 d2", 4'hB, G3);
        #2 reset = 1'b1;
        #1;
        check("rst anode", 32'(bus.ANODE), 32'hF);
        check("rst cathode", 32'(bus.CATHODE), 32'h7F);
        check("rst active", 32'(bus.ACTIVE), 32'd0);
        wait_n(2);
        reset = 1'b0;
        wait_n(40);
        pin("post-reset idle", 4'hF, 7'h7F);
        check("post-reset active", 32'(bus.ACTIVE), 32'd0);

        // Leading-zero behaviour.
        load(16'h0042);
        wait_n(18); pin("0042 d2", Blank ? 4'hF : 4'hB, G0);
        wait_n(8);  pin("0042 d3", Blank ? 4'hF : 4'h7, G0);
        load(16'h0000);
        wait_n(7);  pin("0000 d0", 4'hE, G0);
        wait_n(8);  pin("0000 d1", Blank ? 4'hF : 4'hD, G0);

        // Random LOAD strobes and values, with occasional reset pulses.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            r        = 16'($urandom);
            r        = r >> (4 * $urandom_range(0, 4));
            bus.BCD  = r;
            bus.LOAD = ($urandom_range(0, 15) == 0);
            reset    = ($urandom_range(0, 799) == 0);
        end
        @(negedge clk);
        bus.LOAD = 1'b0;
        reset    = 1'b0;
        wait_n(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
